// File: rtl/router_pkg.sv
// Shared constants and types for the router datapath.
package router_pkg;

  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned HDR_LEN_MSB = 7;
  localparam int unsigned HDR_LEN_LSB = 2;
  localparam int unsigned PKT_CNT_W   = 7;

  // Remaining bytes (payload + parity) of the packet being read out.
  typedef logic [PKT_CNT_W-1:0] pkt_cnt_t;

endpackage

// File: rtl/router_fifo_if.sv
// Write/read handshake and status bundle between router stages and one output FIFO.
interface router_fifo_if
  import router_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
);

  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             pkt_busy;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty, pkt_busy
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty, pkt_busy
  );

endinterface

// File: rtl/router_fifo.sv
// Output-port FIFO: stores {header flag, byte}, tracks occupancy and the
// remaining length of the packet currently being drained.
module router_fifo
  import router_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          soft_reset,
  router_fifo_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [WIDTH:0]   mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  pkt_cnt_t         cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic             full_c;
  logic             empty_c;
  logic             wr_acc_c;
  logic             rd_acc_c;
  logic [WIDTH:0]   rd_entry_c;

  // Status decode and request qualification.
  assign full_c     = (occ_q == OW'(DEPTH));
  assign empty_c    = (occ_q == '0);
  assign wr_acc_c   = bus.write_enb & ~full_c;
  assign rd_acc_c   = bus.read_enb & ~empty_c;
  assign rd_entry_c = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy, packet count and read data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    if (soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      cnt_d    = '0;
      dout_d   = '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        dout_d   = rd_entry_c[WIDTH-1:0];
        if (rd_entry_c[WIDTH]) begin
          // Header: payload length field plus the trailing parity byte.
          cnt_d = PKT_CNT_W'(rd_entry_c[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - PKT_CNT_W'(1);
        end
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is never cleared; occupancy gating keeps stale entries unreachable.
  always_ff @(posedge clock) begin
    if (wr_acc_c && !soft_reset) begin
      mem_q[wr_ptr_q] <= {bus.lfd_state, bus.data_in};
    end
  end

  assign bus.data_out = dout_q;
  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.pkt_busy = (cnt_q != '0);

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter: DEPTH, default 16, number of entries; power of two.
REQ-002 Parameter: WIDTH, default 8, data byte width.
REQ-003 Port: clock  input  1  sole clock; all state changes on posedge clock.
REQ-004 Port: resetn  input  1  asynchronous active-low reset.
REQ-005 Port: soft_reset  input  1  synchronous flush, active high; from the synchronizer's 30-cycle read timeout.
REQ-006 Port: write_enb  input  1  write request for data_in.
REQ-007 Port: read_enb  input  1  read request from the output port consumer.
REQ-008 Port: lfd_state  input  1  high when data_in is a packet header byte.
REQ-009 Port: data_in  input  WIDTH  byte from the router input stage.
REQ-010 Port: data_out  output  WIDTH  registered read data.
REQ-011 Port: full  output  1  high when occupancy equals DEPTH.
REQ-012 Port: empty  output  1  high when occupancy equals 0.
REQ-013 Port: pkt_busy  output  1  high while the current packet's read count is nonzero.

Function
REQ-014 Each entry SHALL store WIDTH+1 bits: {lfd_state, data_in}.
REQ-015 Write SHALL be accepted at a posedge iff write_enb=1 and full=0 before that edge; entry written at wr_ptr, wr_ptr incremented modulo DEPTH.
REQ-016 Read SHALL be accepted at a posedge iff read_enb=1 and empty=0 before that edge; data_out loads entry[rd_ptr][WIDTH-1:0] at that edge (latency 1 cycle), rd_ptr increments modulo DEPTH.
REQ-017 data_out SHALL hold its value on cycles with no accepted read.
REQ-018 Occupancy counter (log2(DEPTH)+1 bits) SHALL +1 on write only, -1 on read only, unchanged on both or neither.
REQ-019 full and empty SHALL be decoded combinationally from the occupancy counter.
REQ-020 Read+write with full=1: read accepted, write dropped; occupancy becomes DEPTH-1.
REQ-021 Read+write with empty=1: write accepted, read ignored, data_out unchanged; occupancy becomes 1.
REQ-022 Read+write with 0<occupancy<DEPTH: both accepted, occupancy unchanged.
REQ-023 Writes while full and reads while empty SHALL have no effect on any state.
REQ-024 On an accepted read of an entry with stored lfd bit=1, packet count SHALL load data[7:2]+1 (payload length plus parity byte), 7-bit unsigned.
REQ-025 On an accepted read of an entry with lfd bit=0 and packet count>0, packet count SHALL decrement by 1; never wraps below 0.
REQ-026 pkt_busy SHALL equal (packet count != 0).
REQ-027 Pointer wrap SHALL be seamless: DEPTH+k total writes interleaved with reads preserve byte order.

Reset
REQ-028 resetn=0 SHALL asynchronously clear wr_ptr, rd_ptr, occupancy, packet count, data_out to 0; empty=1, full=0, pkt_busy=0.
REQ-029 soft_reset=1 at a posedge SHALL produce the same state as REQ-028 at that edge, overriding any same-cycle read or write.
REQ-030 Storage array contents need not be cleared by either reset; stale entries SHALL never be readable because occupancy is 0.
REQ-031 Reset asserted mid-packet SHALL abort the packet; first accepted write after release lands at entry 0.

Structure
REQ-032 Shared package router_pkg SHALL hold FIFO_DEPTH=16, DATA_W=8, HDR_LEN_MSB=7, HDR_LEN_LSB=2, and the 7-bit packet-count type.
REQ-033 Single module, no sub-modules; storage as an in-module register array, three instances per router (one per output port).

Verification
REQ-034 Reset release, write header 0x0C (lfd=1) then 3 bytes 0xA1,0xA2,0xA3 and parity 0x55 -> empty falls after first write, occupancy 5; reads return 0x0C,0xA1,0xA2,0xA3,0x55 each one cycle after read_enb, pkt_busy high after header read, low after parity read.
REQ-035 16 writes 0x00..0x0F, 17th write 0xFF -> full=1 after 16th, 0xFF dropped; 16 reads return 0x00..0x0F then empty=1.
REQ-036 Full FIFO, simultaneous read_enb and write 0x77 -> data_out=0x00, 0x77 dropped, occupancy 15; empty FIFO, simultaneous read and write 0x66 -> data_out unchanged, occupancy 1.
REQ-037 Write 10 bytes, read 8, write 12, read 14 -> pointers wrap, bytes returned in write order, empty=1 at end.
REQ-038 Occupancy 6 with pkt_busy=1, pulse soft_reset for one cycle alongside write_enb -> next cycle empty=1, pkt_busy=0, data_out=0x00, write not stored.
REQ-039 Assert resetn=0 between clock edges mid-packet -> outputs clear immediately without a clock edge; after release header 0x04 read gives packet count 2.
